joystick_adc_reader: RTL and testbench



---
 rtl/joystick_adc_reader.sv | 204 ++++++++++++++++++++
 tb/tb_joystick_adc_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_adc_reader.sv
// Polls a dual-channel 12-bit SPI joystick ADC (MCP3202 framing) and quantizes both axes to 4 bits.
// Define AXIS_DEADZONE_EN to snap codes within DEADZONE of mid-scale to the axis centre value.
module joystick_adc_reader #(
  parameter int unsigned CLK_DIV     = 50,
  parameter int unsigned POLL_CYCLES = 1000000,
  parameter int unsigned X_CENTER    = 7,
  parameter int unsigned Y_CENTER    = 8,
  parameter int unsigned DEADZONE    = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       cs_n_o,
  output logic [3:0] x_axis_o,
  output logic [3:0] y_axis_o,
  output logic       sample_valid_o,
  output logic       busy_o
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PollW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [DivW-1:0]  DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [PollW-1:0] PollLast  = PollW'(POLL_CYCLES - 1);
  localparam logic [3:0]       XCtr      = 4'(X_CENTER);
  localparam logic [3:0]       YCtr      = 4'(Y_CENTER);
  localparam logic [4:0]       FirstData = 5'd5;
  localparam logic [4:0]       LastBit   = 5'd16;

`ifdef AXIS_DEADZONE_EN
  localparam bit DzEn = 1'b1;
`else
  localparam bit DzEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StCsSetup, StShift, StCsHold, StDone} state_e;

  state_e           state_q, state_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic             chan_q, chan_d;
  logic [11:0]      shift_q, shift_d;
  logic [11:0]      raw_x_q, raw_x_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [3:0]       x_q, x_d;
  logic [3:0]       y_q, y_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             div_last;

  // Command: start, SGL, ODD (channel), MSBF, then zeros.
  function automatic logic cmd_bit(input logic [4:0] idx, input logic chan);
    case (idx)
      5'd0, 5'd1, 5'd3: return 1'b1;
      5'd2:             return chan;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] quantize(input logic [11:0] raw, input logic [3:0] centre);
    logic signed [12:0] diff;
    logic [12:0]        mag;
    diff = $signed({1'b0, raw}) - 13'sd2048;
    mag  = diff[12] ? 13'(-diff) : 13'(diff);
    if (DzEn && (32'(mag) <= DEADZONE)) return centre;
    return raw[11:8];
  endfunction

  assign div_last = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    div_d   = div_q;
    bit_d   = bit_q;
    chan_d  = chan_q;
    shift_d = shift_q;
    raw_x_d = raw_x_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (poll_q == PollLast) begin
          poll_d  = '0;
          chan_d  = 1'b0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = cmd_bit(5'd0, 1'b0);
          div_d   = '0;
          state_d = StCsSetup;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      StCsSetup: begin
        if (div_last) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShift: begin
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (bit_q >= FirstData) shift_d = {shift_q[10:0], miso_i};
          end else if (bit_q == LastBit) begin
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            cs_n_d  = 1'b1;
            state_d = StCsHold;
            if (!chan_q) raw_x_d = shift_q;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 5'd1;
            mosi_d = cmd_bit(bit_q + 5'd1, chan_q);
          end
        end
      end
      StCsHold: begin
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!chan_q) begin
            chan_d  = 1'b1;
            cs_n_d  = 1'b0;
            mosi_d  = cmd_bit(5'd0, 1'b1);
            state_d = StCsSetup;
          end else begin
            // Channel 1 code is still in the shifter; both axes commit together.
            x_d     = quantize(raw_x_q, XCtr);
            y_d     = quantize(shift_q, YCtr);
            valid_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      poll_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      chan_q  <= 1'b0;
      shift_q <= '0;
      raw_x_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      x_q     <= XCtr;
      y_q     <= YCtr;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      chan_q  <= chan_d;
      shift_q <= shift_d;
      raw_x_q <= raw_x_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign sclk_o         = sclk_q;
  assign mosi_o         = mosi_q;
  assign cs_n_o         = cs_n_q;
  assign x_axis_o       = x_q;
  assign y_axis_o       = y_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_joystick_adc_reader.sv
// Randomized bench for joystick_adc_reader: SPI ADC device model plus a cycle-level timing model.
module tb_joystick_adc_reader;

  localparam int ClkDiv   = 2;
  localparam int Poll     = 16;
  localparam int FrameLen = 36 * ClkDiv;
  localparam int PairLen  = Poll + 2 * FrameLen + 1;
  localparam int DoneAt   = 2 * FrameLen;
  localparam int Dz       = 128;

`ifdef AXIS_DEADZONE_EN
  localparam bit DzEn = 1'b1;
`else
  localparam bit DzEn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       miso  = 1'b0;
  logic       sclk, mosi, cs_n, valid, busy;
  logic [3:0] x, y;

  always #5 clock = ~clock;

  joystick_adc_reader #(
    .CLK_DIV    (ClkDiv),
    .POLL_CYCLES(Poll),
    .X_CENTER   (7),
    .Y_CENTER   (8),
    .DEADZONE   (Dz)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .miso_i        (miso),
    .sclk_o        (sclk),
    .mosi_o        (mosi),
    .cs_n_o        (cs_n),
    .x_axis_o      (x),
    .y_axis_o      (y),
    .sample_valid_o(valid),
    .busy_o        (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ADC device model ----------------
  logic [11:0] code_x = 12'h000;
  logic [11:0] code_y = 12'h000;
  int          rise_cnt = 0;
  logic [16:0] cmd = '0;
  logic [11:0] sel;

  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      if (!reset) check("sclk_rises_per_frame", rise_cnt, 17);
      rise_cnt <= 0;
    end else begin
      if (rise_cnt < 17) cmd[rise_cnt] <= mosi;
      rise_cnt <= rise_cnt + 1;
    end
  end

  // Next bit goes out on the falling edge; ODD (cmd[2]) picks the channel.
  always @(negedge sclk) begin
    if (!cs_n) begin
      sel = cmd[2] ? code_y : code_x;
      if (rise_cnt >= 5 && rise_cnt <= 16) miso <= sel[16 - rise_cnt];
      else miso <= 1'($urandom_range(0, 1));
    end
  end

  // ---------------- Behavioural timing model ----------------
  int         k = 0;
  bit         in_rst = 1'b1;
  bit         live = 1'b0;
  logic [3:0] ex = 4'd7;
  logic [3:0] ey = 4'd8;

  function automatic int phase(input int kk);
    if (kk < Poll) return -1;
    return (kk - Poll) % PairLen;
  endfunction

  function automatic logic [3:0] quant(input logic [11:0] raw, input logic [3:0] c);
    int d;
    d = int'(raw) - 2048;
    if (DzEn && d <= Dz && d >= -Dz) return c;
    return raw[11:8];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      k      <= 0;
      in_rst <= 1'b1;
      live   <= 1'b1;
      ex     <= 4'd7;
      ey     <= 4'd8;
    end else begin
      in_rst <= 1'b0;
      k      <= k + 1;
      if (phase(k + 1) == DoneAt) begin
        ex <= quant(code_x, 4'd7);
        ey <= quant(code_y, 4'd8);
      end
    end
  end

  int p, o, f, b;
  bit e_cs_lo, e_sck, e_mo, e_bz, e_vl;

  always @(negedge clock) begin
    if (live) begin
      e_cs_lo = 1'b0; e_sck = 1'b0; e_mo = 1'b0; e_bz = 1'b0; e_vl = 1'b0;
      if (!in_rst) begin
        p = phase(k);
        if (p >= 0 && p <= DoneAt) e_bz = 1'b1;
        if (p == DoneAt) e_vl = 1'b1;
        if (p >= 0 && p < DoneAt) begin
          f = p / FrameLen;
          o = p % FrameLen;
          if (o < FrameLen - ClkDiv) begin
            e_cs_lo = 1'b1;
            b = (o < ClkDiv) ? 0 : (o - ClkDiv) / (2 * ClkDiv);
            e_mo = (b == 0 || b == 1 || b == 3) ? 1'b1 : ((b == 2) ? (f == 1) : 1'b0);
            e_sck = (o >= ClkDiv) && (((o - ClkDiv) % (2 * ClkDiv)) >= ClkDiv);
          end
        end
      end
      check("cs_n", int'(cs_n), int'(!e_cs_lo));
      check("sclk", int'(sclk), int'(e_sck));
      check("mosi", int'(mosi), int'(e_mo));
      check("busy", int'(busy), int'(e_bz));
      check("sample_valid", int'(valid), int'(e_vl));
      check("x_axis", int'(x), int'(ex));
      check("y_axis", int'(y), int'(ey));
    end
  end

  // ---------------- Stimulus ----------------
  task automatic wait_cs_fall(output int n);
    for (n = 1; n <= 4 * PairLen; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (!cs_n) return;
    end
    check("cs_fall_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int n);
    for (n = 1; n <= 2 * PairLen + 50; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (valid) return;
    end
    check("valid_timeout", 0, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    code_x = 12'hFFF;
    code_y = 12'h000;
    #1 reset = 1'b0;

    wait_cs_fall(n);
    check("first_cs_fall_delay", n, 16);
    wait_valid(n);
    check("cs_to_valid", n, 144);
    check("full_scale_x", int'(x), 15);
    check("full_scale_y", int'(y), 0);
    @(posedge clock);
    @(negedge clock);
    check("busy_after_done", int'(busy), 0);

    code_x = 12'h9A5;
    code_y = 12'h3C0;
    wait_valid(n);
    check("mid_x", int'(x), 9);
    check("mid_y", int'(y), 3);

    code_x = 12'h870;
    code_y = 12'h7A0;
    wait_valid(n);
    check("near_centre_x", int'(x), DzEn ? 7 : 8);
    check("near_centre_y", int'(y), DzEn ? 8 : 7);

    code_x = 12'h8C0;
    code_y = 12'h700;
    wait_valid(n);
    check("outside_dz_x", int'(x), 8);
    check("outside_dz_y", int'(y), 7);

    for (int i = 0; i < 5; i++) begin
      code_x = 12'($urandom);
      code_y = 12'($urandom);
      wait_valid(n);
      check("valid_interval", n, PairLen);
    end

    // Land on SCLK bit 10 of the channel-1 frame of the next pair.
    repeat (PairLen - DoneAt + FrameLen + ClkDiv + 10 * 2 * ClkDiv) @(posedge clock);
    #1;
    check("mid_frame_cs_low", int'(cs_n), 0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort_cs_n", int'(cs_n), 1);
    check("abort_sclk", int'(sclk), 0);
    check("abort_x", int'(x), 7);
    check("abort_y", int'(y), 8);
    check("abort_valid", int'(valid), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    code_x = 12'($urandom);
    code_y = 12'($urandom);
    wait_cs_fall(n);
    check("restart_cs_fall_delay", n, 16);
    wait_valid(n);
    check("restart_cs_to_valid", n, 144);
    repeat (5) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
